// File: rtl/mult_nxn.sv
// Sequential digit-serial NxN multiplier: one DIGIT x DIGIT partial product per cycle,
// with sign handled by magnitude multiply followed by a conditional negate.
module mult_nxn #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 4
) (
    input  logic               clk,
    input  logic               aclr_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   dataa,
    input  logic [WIDTH-1:0]   datab,
    output logic [2*WIDTH-1:0] product_out,
    output logic               done,
    output logic               busy,
    output logic [2:0]         state_out
);

    localparam int unsigned K  = WIDTH / DIGIT;
    localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StCalc = 3'd1,
        StFix  = 3'd2,
        StDone = 3'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               neg_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] product_q;
    logic [CW-1:0]      i_q, j_q;
    logic               done_q, busy_q;

    logic               accept;
    logic               last;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [DIGIT-1:0]   a_dig, b_dig;
    logic [2*DIGIT-1:0] pp;
    logic [31:0]        shamt;
    logic [2*WIDTH-1:0] pp_shifted;

    // Operands are stored as magnitudes; the sign is reapplied in FIX.
    always_comb begin
        mag_a = dataa;
        mag_b = datab;
        if (signed_mode && dataa[WIDTH-1]) begin
            mag_a = ~dataa + WIDTH'(1);
        end
        if (signed_mode && datab[WIDTH-1]) begin
            mag_b = ~datab + WIDTH'(1);
        end
    end

    always_comb begin
        a_dig      = a_q[i_q*DIGIT +: DIGIT];
        b_dig      = b_q[j_q*DIGIT +: DIGIT];
        pp         = (2*DIGIT)'(a_dig) * (2*DIGIT)'(b_dig);
        shamt      = DIGIT * (32'(i_q) + 32'(j_q));
        pp_shifted = (2*WIDTH)'(pp) << shamt;
    end

    always_comb begin
        accept  = start && ((state_q == StIdle) || (state_q == StDone));
        last    = (i_q == CW'(K - 1)) && (j_q == CW'(K - 1));
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StCalc;
            StCalc:  if (last) state_d = StFix;
            StFix:   state_d = StDone;
            StDone:  state_d = accept ? StCalc : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            product_q <= '0;
            i_q       <= '0;
            j_q       <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == StCalc) || (state_d == StFix);
            done_q  <= (state_d == StDone);
            if (accept) begin
                a_q   <= mag_a;
                b_q   <= mag_b;
                neg_q <= signed_mode & (dataa[WIDTH-1] ^ datab[WIDTH-1]);
                acc_q <= '0;
                i_q   <= '0;
                j_q   <= '0;
            end else if (state_q == StCalc) begin
                acc_q <= acc_q + pp_shifted;
                // j is the inner index; it wraps as i advances.
                if (j_q == CW'(K - 1)) begin
                    j_q <= '0;
                    i_q <= i_q + CW'(1);
                end else begin
                    j_q <= j_q + CW'(1);
                end
            end else if (state_q == StFix) begin
                product_q <= neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
            end
        end
    end

    assign product_out = product_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_mult_nxn.sv
// Bench for mult_nxn: edge-count timing model plus arithmetic reference, checked every
// cycle, with directed scenarios for latency, signed corners, stability, back-to-back, reset.
module tb_mult_nxn;

    localparam int KK = 4;  // K*K for the 8-bit instance

    logic        clk = 1'b0;
    logic        aclr_n = 1'b1;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [7:0]  dataa = '0;
    logic [7:0]  datab = '0;
    logic [15:0] product_out;
    logic        done, busy;
    logic [2:0]  state_out;

    logic        start16 = 1'b0;
    logic        sm16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic [31:0] p16;
    logic        done16, busy16;
    logic [2:0]  st16;

    int checks = 0;
    int failures = 0;

    mult_nxn u_dut (
        .clk         (clk),
        .aclr_n      (aclr_n),
        .start       (start),
        .signed_mode (signed_mode),
        .dataa       (dataa),
        .datab       (datab),
        .product_out (product_out),
        .done        (done),
        .busy        (busy),
        .state_out   (state_out)
    );

    mult_nxn #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk         (clk),
        .aclr_n      (aclr_n),
        .start       (start16),
        .signed_mode (sm16),
        .dataa       (a16),
        .datab       (b16),
        .product_out (p16),
        .done        (done16),
        .busy        (busy16),
        .state_out   (st16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                         input logic s);
        logic signed [15:0] sa, sb;
        logic [15:0] ua, ub;
        sa = $signed({{8{a[7]}}, a});
        sb = $signed({{8{b[7]}}, b});
        ua = {8'h00, a};
        ub = {8'h00, b};
        if (s) return 16'(sa * sb);
        return 16'(ua * ub);
    endfunction

    // Model: an op accepted at edge t is busy after edges t..t+KK, done after t+KK+1,
    // and can be replaced by a new start from edge t+KK+2 on.
    int          edge_n = 0;
    int          acc_edge = 0;
    bit          acc_valid = 1'b0;
    logic [15:0] pend = '0;
    logic [15:0] held = '0;

    always @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            edge_n    <= 0;
            acc_valid <= 1'b0;
            held      <= '0;
        end else begin
            edge_n <= edge_n + 1;
            if (acc_valid && (edge_n + 1 - acc_edge == KK + 1)) held <= pend;
            if (start && (!acc_valid || (edge_n + 1 - acc_edge >= KK + 2))) begin
                acc_valid <= 1'b1;
                acc_edge  <= edge_n + 1;
                pend      <= ref8(dataa, datab, signed_mode);
            end
        end
    end

    always @(negedge clk) begin : cmp
        int rel;
        logic [2:0] es;
        logic eb, ed;
        rel = edge_n - acc_edge;
        es  = 3'd0;
        if (acc_valid && rel >= 0 && rel < KK) es = 3'd1;
        else if (acc_valid && rel == KK) es = 3'd2;
        else if (acc_valid && rel == KK + 1) es = 3'd3;
        eb = (es == 3'd1) || (es == 3'd2);
        ed = (es == 3'd3);
        chk("cyc state_out", 32'(state_out), 32'(es));
        chk("cyc busy", 32'(busy), 32'(eb));
        chk("cyc done", 32'(done), 32'(ed));
        chk("cyc product_out", 32'(product_out), 32'(held));
    end

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [15:0] expp, input string name);
        int lat, busy_n;
        lat = 0;
        busy_n = 0;
        @(negedge clk);
        dataa = a; datab = b; signed_mode = s; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                lat = c;
                break;
            end
        end
        chk({name, " latency"}, 32'(lat), 32'd6);
        chk({name, " product"}, 32'(product_out), 32'(expp));
        chk({name, " busy cycles"}, 32'(busy_n), 32'd5);
    endtask

    task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                           input logic [31:0] expp, input string name);
        int lat;
        lat = 0;
        @(negedge clk);
        a16 = a; b16 = b; sm16 = s; start16 = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start16 = 1'b0;
            if (done16) begin
                lat = c;
                break;
            end
        end
        chk({name, " latency"}, 32'(lat), 32'd18);
        chk({name, " product"}, p16, expp);
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 4))
            0: return 8'h00;
            1: return 8'h80;
            2: return 8'h7F;
            3: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        int n_done;
        logic [15:0] got;

        #1 aclr_n = 1'b0;
        #1;
        chk("reset product_out", 32'(product_out), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset state_out", 32'(state_out), 32'd0);
        chk("reset p16", p16, 32'd0);

        // Pin the reference model against hand-computed values.
        chk("model ff*ff u", 32'(ref8(8'hFF, 8'hFF, 1'b0)), 32'h0000FE01);
        chk("model 80*80 s", 32'(ref8(8'h80, 8'h80, 1'b1)), 32'h00004000);
        chk("model fb*03 s", 32'(ref8(8'hFB, 8'h03, 1'b1)), 32'h0000FFF1);
        chk("model ff*02 s", 32'(ref8(8'hFF, 8'h02, 1'b1)), 32'h0000FFFE);
        chk("model 12*34 u", 32'(ref8(8'h12, 8'h34, 1'b0)), 32'h000003A8);

        repeat (3) @(negedge clk);
        aclr_n = 1'b1;

        do_op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "ff*ff u");
        do_op8(8'h80, 8'h80, 1'b1, 16'h4000, "80*80 s");
        do_op8(8'hFB, 8'h03, 1'b1, 16'hFFF1, "fb*03 s");
        do_op8(8'hFF, 8'h02, 1'b1, 16'hFFFE, "ff*02 s");
        do_op8(8'h00, 8'hA5, 1'b0, 16'h0000, "00*a5 u");
        do_op8(8'hFF, 8'hFF, 1'b1, 16'h0001, "ff*ff s");

        // Input stability: scramble operands and pulse start while busy.
        @(negedge clk);
        dataa = 8'hC8; datab = 8'h0A; signed_mode = 1'b0; start = 1'b1;
        n_done = 0;
        got = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            dataa = 8'($urandom);
            datab = 8'($urandom);
            signed_mode = 1'($urandom);
            start = (c <= 5) ? 1'($urandom) : 1'b0;
            if (done) begin
                n_done++;
                got = product_out;
            end
        end
        chk("stability done count", 32'(n_done), 32'd1);
        chk("stability product", 32'(got), 32'h000007D0);

        // Back-to-back with start held high.
        repeat (3) @(negedge clk);
        start = 1'b1;
        n_done = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            dataa = pick();
            datab = pick();
            signed_mode = 1'($urandom);
            if (done) n_done++;
        end
        start = 1'b0;
        chk("back-to-back done count", 32'(n_done), 32'd5);
        repeat (8) @(negedge clk);

        // Randomized traffic, checked by the per-cycle model.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            dataa = pick();
            datab = pick();
            signed_mode = 1'($urandom);
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
        do_op8(8'hC8, 8'h0A, 1'b0, 16'h07D0, "c8*0a u");

        // Reset during the second CALC cycle.
        @(negedge clk);
        dataa = 8'h55; datab = 8'h66; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 aclr_n = 1'b0;
        #1;
        chk("midop reset product_out", 32'(product_out), 32'd0);
        chk("midop reset done", 32'(done), 32'd0);
        chk("midop reset busy", 32'(busy), 32'd0);
        chk("midop reset state_out", 32'(state_out), 32'd0);
        repeat (3) @(negedge clk);
        #2 aclr_n = 1'b1;
        n_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("no done after reset", 32'(n_done), 32'd0);
        do_op8(8'h12, 8'h34, 1'b0, 16'h03A8, "12*34 u");

        do_op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16 ffff*ffff u");
        do_op16(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, "w16 8000*7fff s");

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_nxn.md
MULT_NXN -- requirements
Module: mult_nxn

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; SHALL be a multiple of DIGIT and at least DIGIT.
REQ-002 SHALL have parameter DIGIT, default 4: partial-product digit width in bits; K = WIDTH/DIGIT digits per operand.
REQ-003 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 Port aclr_n  in  1: reset, asynchronous and active-low.
REQ-005 Port start  in  1: request a multiply; sampled on the rising edge of clk.
REQ-006 Port signed_mode  in  1: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 Port dataa  in  WIDTH: multiplicand; sampled with start.
REQ-008 Port datab  in  WIDTH: multiplier; sampled with start.
REQ-009 Port product_out  out  2*WIDTH: registered result.
REQ-010 Port done  out  1: registered one-cycle completion pulse.
REQ-011 Port busy  out  1: registered; high while an operation is in progress.
REQ-012 Port state_out  out  3: registered state code for the seven-segment display: IDLE=0, CALC=1, FIX=2, DONE=3.

Function
REQ-013 States SHALL be IDLE, CALC, FIX and DONE, encoded as in REQ-012.
REQ-014 Start acceptance: in IDLE or DONE with start=1 at an edge, the block SHALL latch dataa, datab and signed_mode, clear the accumulator and digit counter, and enter CALC.
REQ-015 Inputs after acceptance: changes on dataa, datab and signed_mode SHALL NOT affect the operation in progress.
REQ-016 start in CALC or FIX SHALL be ignored: no restart and no queuing.
REQ-017 Signed latch: with signed_mode=1, the block SHALL latch the magnitude of each operand as a WIDTH-bit unsigned value (-2^(WIDTH-1) gives 2^(WIDTH-1)) and SHALL record result sign = XOR of the operand MSBs.
REQ-018 Unsigned latch: with signed_mode=0, the block SHALL latch the operands unchanged and SHALL record result sign = 0.
REQ-019 CALC SHALL last exactly K*K cycles; one partial product per cycle, i = outer digit index of A (0..K-1), j = inner digit index of B (0..K-1), counter wrapping j to 0 as i increments.
REQ-020 Each CALC cycle SHALL add (A digit i x B digit j), a 2*DIGIT-bit unsigned product zero-extended and shifted left by DIGIT*(i+j), into a 2*WIDTH-bit accumulator, modulo 2^(2*WIDTH).
REQ-021 After the last partial product, the block SHALL enter FIX for one cycle.
REQ-022 In FIX, product_out SHALL load the two's-complement negation of the accumulator if the recorded sign is 1, otherwise the accumulator unchanged.
REQ-023 After FIX, the block SHALL enter DONE for one cycle with done=1, then return to IDLE unless a start is accepted per REQ-014.
REQ-024 Latency: counting the edge that samples start as edge 1, done SHALL be high in the cycle after edge K*K+2, i.e. 6 cycles for WIDTH=8, DIGIT=4.
REQ-025 busy SHALL be 1 in CALC and FIX and 0 in IDLE and DONE.
REQ-026 product_out SHALL hold its value until the next FIX, including through IDLE and a new CALC.
REQ-027 Back-to-back: start in DONE SHALL be accepted; done SHALL fall after one cycle and busy SHALL rise on the same edge.

Reset
REQ-028 While aclr_n=0, the block SHALL hold product_out=0, done=0, busy=0, state_out=0, with the accumulator, counter, latched operands and sign cleared and state=IDLE, regardless of clk.
REQ-029 Reset asserted mid-operation SHALL abandon the operation without producing a done pulse.
REQ-030 After release, the first start SHALL be honoured at the first rising edge with aclr_n=1.

Verification
REQ-031 Scenario, defaults, unsigned: 0xFF x 0xFF -> product_out=0xFE01 with done at the edge-6 cycle per REQ-024; busy high for exactly 5 cycles.
REQ-032 Scenario, signed: 0x80 x 0x80 -> 0x4000; 0xFB x 0x03 -> 0xFFF1; 0xFF x 0x02 -> 0xFFFE; unsigned 0x00 x 0xA5 -> 0x0000.
REQ-033 Scenario, input stability: change dataa/datab every cycle during CALC and pulse start during CALC/FIX -> result equals the operands latched at acceptance and exactly one done.
REQ-034 Scenario, back-to-back: start held high continuously -> done pulses every 6 cycles (accepted in DONE); product_out updates each operation.
REQ-035 Scenario, reset: drop aclr_n during the 2nd CALC cycle -> all outputs 0 immediately and no done; after release, 0x12 x 0x34 -> 0x03A8.
REQ-036 Scenario, WIDTH=16, DIGIT=4: unsigned 0xFFFF x 0xFFFF -> 0xFFFE0001 with done at the edge-18 cycle; signed 0x8000 x 0x7FFF -> 0xC0008000.
